risc16_fetch_stage: RTL and testbench

Instruction-fetch stage of the RiSC-16 pipeline. Owns the program counter, drives the word address of the combinational-read instruction memory, and registers the returned instruction into the IF/ID pipeline register. Supports pipeline stall, branch/jump redirect with flush, and halt detection, which freezes fetch until a redirect arrives.

---
 rtl/risc16_fetch_stage.sv | 104 ++++++++++
 tb/tb_risc16_fetch_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/risc16_fetch_stage.sv
// ---------------------------------------------------------------------------
// risc16_fetch_stage
//   Instruction-fetch stage of the RiSC-16 pipeline. Holds the program
//   counter, presents it as the word address of a combinational-read
//   instruction memory, and captures the returned word into the IF/ID
//   pipeline register. Supports stall, redirect with flush, and halt
//   detection that freezes fetch until a redirect arrives.
//
// Parameters
//   RESET_PC     PC value loaded on reset.
//   HALT_DETECT  1: a fetched halt word freezes fetch; 0: never detected.
//
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   stall          in   hold PC and IF/ID this cycle
//   redirect_valid in   load redirect_pc as next PC, flush IF/ID
//   redirect_pc    in   [15:0] redirect target (word address)
//   imem_addr      out  [15:0] instruction address (current PC)
//   imem_data      in   [15:0] instruction word for imem_addr
//   ifid_valid     out  IF/ID holds a real instruction
//   ifid_instr     out  [15:0] registered instruction
//   ifid_pc        out  [15:0] PC of ifid_instr
//   ifid_pc_plus1  out  [15:0] ifid_pc + 1 (JALR link value)
//   halted         out  fetch frozen on a halt
// ---------------------------------------------------------------------------
module risc16_fetch_stage #(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter bit          HALT_DETECT = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [15:0] redirect_pc,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_data,
   output logic        ifid_valid,
   output logic [15:0] ifid_instr,
   output logic [15:0] ifid_pc,
   output logic [15:0] ifid_pc_plus1,
   output logic        halted
);

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

   state_t      r_state;
   logic [15:0] r_pc;
   logic        r_ifid_valid;
   logic [15:0] r_ifid_instr;
   logic [15:0] r_ifid_pc;
   logic        w_is_halt;

   // Halt is a JALR (opcode 111) with a non-zero immediate field;
   // a plain JALR (imm = 0) is an ordinary jump.
   assign w_is_halt = HALT_DETECT && (imem_data[15:13] == 3'b111) &&
                      (imem_data[6:0] != 7'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc         <= RESET_PC;
         r_state      <= ST_RUN;
         r_ifid_valid <= 1'b0;
         r_ifid_instr <= '0;
         r_ifid_pc    <= '0;
      end else if (redirect_valid) begin
         // Redirect beats stall and also cancels a halt fetched on a wrong path.
         r_pc         <= redirect_pc;
         r_state      <= ST_RUN;
         r_ifid_valid <= 1'b0;
      end else if (!stall) begin
         case (r_state)
            ST_RUN: begin
               // The halt word itself still goes downstream so it can retire.
               r_ifid_instr <= imem_data;
               r_ifid_pc    <= r_pc;
               r_ifid_valid <= 1'b1;
               if (w_is_halt) begin
                  r_state <= ST_HALTED;
               end else begin
                  r_pc <= r_pc + 16'd1;
               end
            end
            ST_HALTED: begin
               r_ifid_valid <= 1'b0;
            end
            default: begin
               r_state <= ST_RUN;
            end
         endcase
      end
   end

   assign imem_addr     = r_pc;
   assign ifid_valid    = r_ifid_valid;
   assign ifid_instr    = r_ifid_instr;
   assign ifid_pc       = r_ifid_pc;
   assign ifid_pc_plus1 = r_ifid_pc + 16'd1;
   assign halted        = (r_state == ST_HALTED);

endmodule

// File: tb/tb_risc16_fetch_stage.sv
module tb_risc16_fetch_stage;

   logic        clk;
   logic        rst_n;

   // Instance A: RESET_PC = 0, memory model below
   logic        a_stall;
   logic        a_redirect_valid;
   logic [15:0] a_redirect_pc;
   logic [15:0] a_imem_addr;
   logic [15:0] a_imem_data;
   logic        a_ifid_valid;
   logic [15:0] a_ifid_instr;
   logic [15:0] a_ifid_pc;
   logic [15:0] a_ifid_pc_plus1;
   logic        a_halted;

   // Instance B: RESET_PC = FFFE, never stalled or redirected
   logic        b_stall;
   logic        b_redirect_valid;
   logic [15:0] b_redirect_pc;
   logic [15:0] b_imem_addr;
   logic [15:0] b_imem_data;
   logic        b_ifid_valid;
   logic [15:0] b_ifid_instr;
   logic [15:0] b_ifid_pc;
   logic [15:0] b_ifid_pc_plus1;
   logic        b_halted;

   logic [15:0] mem [0:255];

   int n_tests;
   int n_fail;

   risc16_fetch_stage #(.RESET_PC(16'h0000), .HALT_DETECT(1'b1)) u_dut_a (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall          (a_stall),
      .redirect_valid (a_redirect_valid),
      .redirect_pc    (a_redirect_pc),
      .imem_addr      (a_imem_addr),
      .imem_data      (a_imem_data),
      .ifid_valid     (a_ifid_valid),
      .ifid_instr     (a_ifid_instr),
      .ifid_pc        (a_ifid_pc),
      .ifid_pc_plus1  (a_ifid_pc_plus1),
      .halted         (a_halted)
   );

   risc16_fetch_stage #(.RESET_PC(16'hFFFE), .HALT_DETECT(1'b1)) u_dut_b (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall          (b_stall),
      .redirect_valid (b_redirect_valid),
      .redirect_pc    (b_redirect_pc),
      .imem_addr      (b_imem_addr),
      .imem_data      (b_imem_data),
      .ifid_valid     (b_ifid_valid),
      .ifid_instr     (b_ifid_instr),
      .ifid_pc        (b_ifid_pc),
      .ifid_pc_plus1  (b_ifid_pc_plus1),
      .halted         (b_halted)
   );

   assign a_imem_data = mem[a_imem_addr[7:0]];
   // Top three bits forced to 000 so instance B never sees a halt word.
   assign b_imem_data = b_imem_addr & 16'h1FFF;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      for (int i = 0; i < 256; i++) mem[i] = 16'((i * 3) & 16'h1FFF);
      mem[0]    = 16'h2481;
      mem[1]    = 16'h0123;
      mem[2]    = 16'h4A05;
      mem[3]    = 16'h8C02;
      mem[4]    = 16'h6C33;
      mem[16]   = 16'h3210;
      mem[64]   = 16'hA5C3;
      mem[65]   = 16'hE080;   // plain JALR: imm field zero, bit 7 set

      rst_n = 1'b0;
      a_stall = 1'b0; a_redirect_valid = 1'b0; a_redirect_pc = '0;
      b_stall = 1'b0; b_redirect_valid = 1'b0; b_redirect_pc = '0;

      // Reset values
      @(negedge clk);
      chk("rst_addr",   a_imem_addr, 16'h0000);
      chk("rst_valid",  16'(a_ifid_valid), 16'd0);
      chk("rst_instr",  a_ifid_instr, 16'h0000);
      chk("rst_pc",     a_ifid_pc, 16'h0000);
      chk("rst_plus1",  a_ifid_pc_plus1, 16'h0001);
      chk("rst_halted", 16'(a_halted), 16'd0);
      chk("rst_b_addr", b_imem_addr, 16'hFFFE);
      rst_n = 1'b1;

      // Sequential fetch
      tick();
      chk("f0_pc",    a_ifid_pc, 16'h0000);
      chk("f0_instr", a_ifid_instr, 16'h2481);
      chk("f0_valid", 16'(a_ifid_valid), 16'd1);
      chk("f0_plus1", a_ifid_pc_plus1, 16'h0001);
      chk("f0_addr",  a_imem_addr, 16'h0001);
      chk("b0_pc",    b_ifid_pc, 16'hFFFE);
      chk("b0_addr",  b_imem_addr, 16'hFFFF);
      chk("b0_instr", b_ifid_instr, 16'h1FFE);
      tick();
      chk("f1_pc",    a_ifid_pc, 16'h0001);
      chk("f1_instr", a_ifid_instr, 16'h0123);
      chk("f1_plus1", a_ifid_pc_plus1, 16'h0002);
      chk("f1_addr",  a_imem_addr, 16'h0002);
      chk("b1_pc",    b_ifid_pc, 16'hFFFF);
      chk("b1_plus1", b_ifid_pc_plus1, 16'h0000);
      chk("b1_addr",  b_imem_addr, 16'h0000);

      // Stall for three cycles while ifid_pc = 1
      a_stall = 1'b1;
      tick();
      chk("s1_pc",    a_ifid_pc, 16'h0001);
      chk("s1_instr", a_ifid_instr, 16'h0123);
      chk("s1_valid", 16'(a_ifid_valid), 16'd1);
      chk("s1_addr",  a_imem_addr, 16'h0002);
      chk("b2_pc",    b_ifid_pc, 16'h0000);
      chk("b2_plus1", b_ifid_pc_plus1, 16'h0001);
      tick();
      chk("s2_pc",    a_ifid_pc, 16'h0001);
      chk("s2_addr",  a_imem_addr, 16'h0002);
      tick();
      chk("s3_pc",    a_ifid_pc, 16'h0001);
      chk("s3_instr", a_ifid_instr, 16'h0123);
      chk("s3_addr",  a_imem_addr, 16'h0002);
      a_stall = 1'b0;
      tick();
      chk("f2_pc",    a_ifid_pc, 16'h0002);
      chk("f2_instr", a_ifid_instr, 16'h4A05);
      chk("f2_valid", 16'(a_ifid_valid), 16'd1);
      tick();
      chk("f3_pc",    a_ifid_pc, 16'h0003);
      chk("f3_instr", a_ifid_instr, 16'h8C02);
      tick();
      chk("f4_pc",    a_ifid_pc, 16'h0004);
      chk("f4_instr", a_ifid_instr, 16'h6C33);
      chk("f4_addr",  a_imem_addr, 16'h0005);

      // Redirect together with stall while pc = 5: redirect wins
      a_stall = 1'b1;
      a_redirect_valid = 1'b1;
      a_redirect_pc = 16'h0040;
      tick();
      chk("r_addr",  a_imem_addr, 16'h0040);
      chk("r_valid", 16'(a_ifid_valid), 16'd0);
      a_stall = 1'b0;
      a_redirect_valid = 1'b0;
      tick();
      chk("r1_pc",    a_ifid_pc, 16'h0040);
      chk("r1_instr", a_ifid_instr, 16'hA5C3);
      chk("r1_valid", 16'(a_ifid_valid), 16'd1);
      tick();
      chk("jalr_pc",     a_ifid_pc, 16'h0041);
      chk("jalr_instr",  a_ifid_instr, 16'hE080);
      chk("jalr_halted", 16'(a_halted), 16'd0);
      chk("jalr_addr",   a_imem_addr, 16'h0042);

      // Asynchronous reset mid-cycle (clock is low here, next edge 5 units away)
      rst_n = 1'b0;
      #1;
      chk("ar_addr",   a_imem_addr, 16'h0000);
      chk("ar_valid",  16'(a_ifid_valid), 16'd0);
      chk("ar_instr",  a_ifid_instr, 16'h0000);
      chk("ar_pc",     a_ifid_pc, 16'h0000);
      chk("ar_plus1",  a_ifid_pc_plus1, 16'h0001);
      chk("ar_b_addr", b_imem_addr, 16'hFFFE);
      mem[3] = 16'hE071;
      #1;
      rst_n = 1'b1;

      // Halt at word 3
      tick();
      chk("h0_pc", a_ifid_pc, 16'h0000);
      tick();
      chk("h1_pc", a_ifid_pc, 16'h0001);
      tick();
      chk("h2_pc",     a_ifid_pc, 16'h0002);
      chk("h2_addr",   a_imem_addr, 16'h0003);
      chk("h2_halted", 16'(a_halted), 16'd0);
      tick();
      chk("h3_pc",     a_ifid_pc, 16'h0003);
      chk("h3_instr",  a_ifid_instr, 16'hE071);
      chk("h3_valid",  16'(a_ifid_valid), 16'd1);
      chk("h3_halted", 16'(a_halted), 16'd1);
      chk("h3_addr",   a_imem_addr, 16'h0003);
      tick();
      chk("h4_valid",  16'(a_ifid_valid), 16'd0);
      chk("h4_halted", 16'(a_halted), 16'd1);
      chk("h4_addr",   a_imem_addr, 16'h0003);
      tick();
      chk("h5_valid",  16'(a_ifid_valid), 16'd0);
      chk("h5_addr",   a_imem_addr, 16'h0003);

      // Redirect out of HALTED
      a_redirect_valid = 1'b1;
      a_redirect_pc = 16'h0010;
      tick();
      chk("hr_halted", 16'(a_halted), 16'd0);
      chk("hr_addr",   a_imem_addr, 16'h0010);
      chk("hr_valid",  16'(a_ifid_valid), 16'd0);
      a_redirect_valid = 1'b0;
      tick();
      chk("hr1_pc",    a_ifid_pc, 16'h0010);
      chk("hr1_instr", a_ifid_instr, 16'h3210);
      chk("hr1_valid", 16'(a_ifid_valid), 16'd1);
      chk("hr1_addr",  a_imem_addr, 16'h0011);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
